// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, write-type encoding, mstatus fields, mcause codes.
package csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CSR_DATA_W = 32;
  localparam int unsigned CAUSE_W    = 5;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam logic [31:0] MSTATUS_MPP_M    = 32'h0000_1800;

  localparam logic [4:0] CAUSE_INSN_MISALIGNED = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL_INSN    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT      = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M         = 5'd11;

  typedef enum logic [1:0] {
    WT_NOP   = 2'b00,
    WT_WRITE = 2'b01,
    WT_SET   = 2'b10,
    WT_CLEAR = 2'b11
  } write_type_e;

  // New CSR value for a csrrw/csrrs/csrrc style update of old by din.
  function automatic logic [31:0] csr_wdata(input logic [31:0] old,
                                            input logic [31:0] din,
                                            input write_type_e wt);
    logic [31:0] res;
    res = old;
    case (wt)
      WT_WRITE: res = din;
      WT_SET:   res = old | din;
      WT_CLEAR: res = old & ~din;
      default:  res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_reg_file_if.sv
// Control/handshake signals between the sequencer (master) and the CSR file (slave).
// The shared tri-state data bus is a plain inout net on the CSR file, not part of this bundle.
interface csr_reg_file_if;

  logic [csr_pkg::CSR_ADDR_W-1:0] addr;
  logic                           read;
  logic                           write;
  logic [1:0]                     write_type;
  logic                           trap;
  logic [csr_pkg::CAUSE_W-1:0]    trap_cause;
  logic                           ret;
  logic                           invalid;

  modport master (
    output addr, read, write, write_type, trap, trap_cause, ret,
    input  invalid
  );

  modport slave (
    input  addr, read, write, write_type, trap, trap_cause, ret,
    output invalid
  );

endinterface

// File: rtl/csr_counter.sv
// 64-bit free-running cycle counter; a write to either half replaces it and skips that increment.
module csr_counter
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  // Count every clock unless a half is being written this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 64'd0;
    end else if (i_wr_lo) begin
      r_count[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_count[63:32] <= i_wdata;
    end else begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode CSR file for the multi-cycle RV32I core.
// Optional feature: define CSR_COUNTERS_EN to add the mcycle/mcycleh/cycle/cycleh counter.
module csr_reg_file
  import csr_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
)(
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] bus,
  csr_reg_file_if.slave csr
);

  logic        r_mie_b;
  logic        r_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mscratch;
  logic [29:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic        w_impl;
  logic        w_invalid;
  logic        w_wr_en;
  logic [31:0] w_mstatus;
  logic [31:0] w_rdata;
  logic [31:0] w_new;

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_count;
  logic        w_cnt_wr_lo;
  logic        w_cnt_wr_hi;

  assign w_cnt_wr_lo = w_wr_en && (csr.addr == ADDR_MCYCLE);
  assign w_cnt_wr_hi = w_wr_en && (csr.addr == ADDR_MCYCLEH);

  csr_counter u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_wr_lo (w_cnt_wr_lo),
    .i_wr_hi (w_cnt_wr_hi),
    .i_wdata (w_new),
    .o_count (w_count)
  );
`endif

  // Address decode: which CSRs exist in this build.
  always_comb begin
    w_impl = 1'b0;
    case (csr.addr)
      ADDR_MSTATUS, ADDR_MISA, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
      ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL, ADDR_MIP,
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MHARTID: w_impl = 1'b1;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_CYCLE, ADDR_CYCLEH:       w_impl = 1'b1;
`endif
      default: w_impl = 1'b0;
    endcase
  end

  // Illegal access: unknown address, or a write into the read-only 0xC00-0xFFF region.
  assign w_invalid = (csr.read || csr.write) &&
                     (!w_impl || (csr.write && (csr.addr[11:10] == 2'b11)));
  assign csr.invalid = w_invalid;

  assign w_wr_en = csr.write && !w_invalid && !csr.trap;

  // Read mux; also supplies the pre-edge value for set/clear updates.
  always_comb begin
    w_mstatus                   = MSTATUS_MPP_M;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mie_b;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mpie;
    w_rdata = 32'd0;
    case (csr.addr)
      ADDR_MSTATUS:  w_rdata = w_mstatus;
      ADDR_MISA:     w_rdata = MISA_VALUE;
      ADDR_MIE:      w_rdata = r_mie;
      ADDR_MTVEC:    w_rdata = TRAP_VECTOR;
      ADDR_MSCRATCH: w_rdata = r_mscratch;
      ADDR_MEPC:     w_rdata = {r_mepc, 2'b00};
      ADDR_MCAUSE:   w_rdata = r_mcause;
      ADDR_MTVAL:    w_rdata = r_mtval;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,  ADDR_CYCLE:  w_rdata = w_count[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH: w_rdata = w_count[63:32];
`endif
      default:       w_rdata = 32'd0;
    endcase
  end

  assign w_new = csr_wdata(w_rdata, bus, write_type_e'(csr.write_type));

  // Drive the shared bus only for a legal read.
  assign bus = (csr.read && !w_invalid) ? w_rdata : 32'bz;

  // CSR state: trap entry beats write and mret; mret overrides a same-cycle mstatus write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mie_b    <= 1'b0;
      r_mpie     <= 1'b0;
      r_mie      <= 32'd0;
      r_mscratch <= 32'd0;
      r_mepc     <= 30'd0;
      r_mcause   <= 32'd0;
      r_mtval    <= 32'd0;
    end else if (csr.trap) begin
      r_mepc   <= bus[31:2];
      r_mcause <= {27'd0, csr.trap_cause};
      r_mtval  <= 32'd0;
      r_mpie   <= r_mie_b;
      r_mie_b  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        case (csr.addr)
          ADDR_MSTATUS: begin
            r_mie_b <= w_new[MSTATUS_MIE_BIT];
            r_mpie  <= w_new[MSTATUS_MPIE_BIT];
          end
          ADDR_MIE:      r_mie      <= w_new;
          ADDR_MSCRATCH: r_mscratch <= w_new;
          ADDR_MEPC:     r_mepc     <= w_new[31:2];
          ADDR_MCAUSE:   r_mcause   <= w_new;
          ADDR_MTVAL:    r_mtval    <= w_new;
          default: ;
        endcase
      end
      if (csr.ret) begin
        r_mie_b <= r_mpie;
        r_mpie  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_reg_file.sv
// Scoreboard bench for csr_reg_file: stimulus queues expected responses, a negedge monitor checks them.
module tb_csr_reg_file;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  wire  [31:0] bus;
  logic [31:0] r_tb_bus;
  logic        r_tb_drv;

  csr_reg_file_if u_if ();

  assign bus = r_tb_drv ? r_tb_bus : 32'bz;

  csr_reg_file u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .csr (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_bus;
    logic [31:0] bus;
    logic        inv;
    string       name;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every read/write cycle presents a response; compare it with the oldest expectation.
  always @(negedge clk) begin
    if (rst && (u_if.read || u_if.write)) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_access addr=%h no expectation queued", u_if.addr);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        n_tests++;
        if (u_if.invalid !== e.inv) begin
          n_fail++;
          $display("FAIL %s invalid got=%b exp=%b", e.name, u_if.invalid, e.inv);
        end
        if (e.chk_bus) begin
          n_tests++;
          if (bus !== e.bus) begin
            n_fail++;
            $display("FAIL %s bus got=%h exp=%h", e.name, bus, e.bus);
          end
        end
      end
    end
  end

  task automatic idle();
    u_if.addr       = 12'h000;
    u_if.read       = 1'b0;
    u_if.write      = 1'b0;
    u_if.write_type = 2'b00;
    u_if.trap       = 1'b0;
    u_if.trap_cause = 5'd0;
    u_if.ret        = 1'b0;
    r_tb_drv        = 1'b0;
    r_tb_bus        = 32'd0;
  endtask

  // One bus cycle; expectation is queued when the cycle is a read or write.
  task automatic op(input string nm, input logic [11:0] a, input logic rd, input logic wr,
                    input logic [1:0] wt, input logic drv, input logic [31:0] dv,
                    input logic tr, input logic [4:0] cause, input logic rt,
                    input logic chk, input logic [31:0] eb, input logic ei);
    exp_t e;
    u_if.addr       = a;
    u_if.read       = rd;
    u_if.write      = wr;
    u_if.write_type = wt;
    u_if.trap       = tr;
    u_if.trap_cause = cause;
    u_if.ret        = rt;
    r_tb_drv        = drv;
    r_tb_bus        = dv;
    if (rd || wr) begin
      e.chk_bus = chk;
      e.bus     = eb;
      e.inv     = ei;
      e.name    = nm;
      q_exp.push_back(e);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] eb);
    op(nm, a, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, eb, 1'b0);
  endtask

  task automatic rd_inv(input string nm, input logic [11:0] a);
    op(nm, a, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic wr(input string nm, input logic [11:0] a, input logic [1:0] wt,
                    input logic [31:0] v, input logic ei);
    op(nm, a, 1'b0, 1'b1, wt, 1'b1, v, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, ei);
  endtask

  task automatic trap(input logic [31:0] pc, input logic [4:0] cause);
    op("trap", 12'h000, 1'b0, 1'b0, 2'b00, 1'b1, pc, 1'b1, cause, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Reset values and constant CSRs
    rd("rst_mstatus",  12'h300, 32'h0000_1800);
    rd("rst_mepc",     12'h341, 32'h0);
    rd("rst_mcause",   12'h342, 32'h0);
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("misa",         12'h301, 32'h4000_0100);
    rd("mtvec",        12'h305, 32'h0000_0004);
    rd("mhartid",      12'hF14, 32'h0);
    rd("mip",          12'h344, 32'h0);

    // Plain write/readback
    wr("wr_mscratch", 12'h340, 2'b01, 32'hDEAD_BEEF, 1'b0);
    rd("rd_mscratch", 12'h340, 32'hDEAD_BEEF);

    // Set/clear read-modify-write
    wr("wr_f0f0",  12'h340, 2'b01, 32'h0000_F0F0, 1'b0);
    wr("set_0f00", 12'h340, 2'b10, 32'h0000_0F00, 1'b0);
    rd("rd_fff0",  12'h340, 32'h0000_FFF0);
    wr("clr_00f0", 12'h340, 2'b11, 32'h0000_00F0, 1'b0);
    rd("rd_ff00",  12'h340, 32'h0000_FF00);
    wr("nop_wt00", 12'h340, 2'b00, 32'h1234_5678, 1'b0);
    rd("rd_nop",   12'h340, 32'h0000_FF00);

    // mie full register
    wr("wr_mie", 12'h304, 2'b01, 32'h0000_0888, 1'b0);
    rd("rd_mie", 12'h304, 32'h0000_0888);

    // Trap entry
    wr("wr_mtval",   12'h343, 2'b01, 32'h0000_0055, 1'b0);
    wr("mie_on",     12'h300, 2'b01, 32'h0000_0008, 1'b0);
    rd("rd_mie_on",  12'h300, 32'h0000_1808);
    trap(32'h0000_0104, 5'd2);
    rd("trap_mepc",    12'h341, 32'h0000_0104);
    rd("trap_mcause",  12'h342, 32'h0000_0002);
    rd("trap_mtval",   12'h343, 32'h0);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);

    // mret with same-cycle mepc read
    op("ret_mepc", 12'h341, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0, 5'd0, 1'b1,
       1'b1, 32'h0000_0104, 1'b0);
    rd("ret_mstatus", 12'h300, 32'h0000_1888);

    // Illegal / read-only accesses
    rd_inv("rd_7c0", 12'h7C0);
    wr("wr_f11", 12'hF11, 2'b01, 32'hFFFF_FFFF, 1'b1);
    rd("rd_f11", 12'hF11, 32'h0);
    wr("wr_misa", 12'h301, 2'b01, 32'hFFFF_FFFF, 1'b0);
    rd("rd_misa", 12'h301, 32'h4000_0100);
    wr("wr_mtvec", 12'h305, 2'b01, 32'h0000_1000, 1'b0);
    rd("rd_mtvec", 12'h305, 32'h0000_0004);
    wr("wr_mip", 12'h344, 2'b01, 32'hFFFF_FFFF, 1'b0);
    rd("rd_mip", 12'h344, 32'h0);

    // Trap and write on the same edge: trap wins
    op("trap_wr", 12'h340, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0208, 1'b1, 5'd5, 1'b0,
       1'b0, 32'd0, 1'b0);
    rd("tw_mscratch", 12'h340, 32'h0000_FF00);
    rd("tw_mepc",     12'h341, 32'h0000_0208);
    rd("tw_mcause",   12'h342, 32'h0000_0005);
    rd("tw_mstatus",  12'h300, 32'h0000_1880);

    // mret overrides a simultaneous mstatus write
    op("ret_wr", 12'h300, 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0000, 1'b0, 5'd0, 1'b1,
       1'b0, 32'd0, 1'b0);
    rd("rw_mstatus", 12'h300, 32'h0000_1888);

    // mepc low bits read as zero
    wr("wr_mepc", 12'h341, 2'b01, 32'h0000_0123, 1'b0);
    rd("rd_mepc", 12'h341, 32'h0000_0120);

`ifdef CSR_COUNTERS_EN
    wr("wr_mcycle", 12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #1;
    rd("rd_mcycleh", 12'hB80, 32'h0000_0001);
    rd("rd_cycleh",  12'hC80, 32'h0000_0001);
    wr("wr_cycle_ro", 12'hC00, 2'b01, 32'h0, 1'b1);
`else
    rd_inv("no_mcycle",  12'hB00);
    rd_inv("no_mcycleh", 12'hB80);
    rd_inv("no_cycle",   12'hC00);
    wr("no_wr_mcycle", 12'hB00, 2'b01, 32'h1, 1'b1);
`endif

    // Reset mid-run clears state
    do_reset();
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mstatus",  12'h300, 32'h0000_1800);
    rd("rst2_mepc",     12'h341, 32'h0);
    rd("rst2_mie",      12'h304, 32'h0);
`ifdef CSR_COUNTERS_EN
    rd("rst2_mcycleh",  12'hB80, 32'h0);
`endif

    repeat (2) @(posedge clk);
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue got=%0d exp=0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
